// File: rtl/pio_pkg.sv
// Shared constants for the bidirectional Avalon PIO: register map, edge modes
// and the edge-detect helper used by the synchroniser.
package pio_pkg;

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned MAX_W    = 32;

  // Register map
  localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd5;

  // Edge capture modes
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Per-bit edge pulse from current and previous synchronised values
  function automatic logic [MAX_W-1:0] edge_detect(input int unsigned mode,
                                                   input logic [MAX_W-1:0] cur,
                                                   input logic [MAX_W-1:0] prev);
    logic [MAX_W-1:0] ev;
    case (mode)
      EDGE_FALL: ev = ~cur & prev;
      EDGE_ANY:  ev = cur ^ prev;
      default:   ev = cur & ~prev;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/avalon_pio_bidir_if.sv
// Avalon-MM slave bus bundle for the PIO register block.
interface avalon_pio_bidir_if #(
  parameter int unsigned WIDTH = 8
);

  logic [pio_pkg::ADDR_W-1:0] address;
  logic                       chipselect;
  logic                       write_n;
  logic [WIDTH-1:0]           writedata;
  logic [WIDTH-1:0]           readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/pio_edge_sync.sv
// Two-flop input synchroniser plus history flop and edge detector, vectorised
// over WIDTH. All flops reset to 0, so a pin held high through reset release
// yields exactly one rising edge and never a falling one.
module pio_edge_sync
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EDGE_MODE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] edge_c
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] hist_q;

  // Synchroniser chain and one-cycle history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Edge pulse selected by EDGE_MODE
  always_comb begin
    edge_c = WIDTH'(edge_detect(EDGE_MODE, MAX_W'(sync2_q), MAX_W'(hist_q)));
  end

  assign sync_q = sync2_q;

endmodule

// File: rtl/avalon_pio_bidir.sv
// Bidirectional Avalon-MM PIO: output register, direction, interrupt mask and
// edge capture with level interrupt. Zero-wait-state combinational reads.
// Optional feature macro: PIO_BITSET_EN adds OUTSET (addr 4) and OUTCLR
// (addr 5) atomic bit set/clear of the output register.
module avalon_pio_bidir
  import pio_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter int unsigned      EDGE_MODE = EDGE_RISE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  avalon_pio_bidir_if.slave    bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic [WIDTH-1:0]     out_port,
  output logic [WIDTH-1:0]     out_en,
  output logic                 irq
);

  logic [WIDTH-1:0] out_q, out_next;
  logic [WIDTH-1:0] dir_q, dir_next;
  logic [WIDTH-1:0] mask_q, mask_next;
  logic [WIDTH-1:0] cap_q, cap_next;
  logic             irq_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] edge_c;
  logic             wr_c;

  pio_edge_sync #(
    .WIDTH     (WIDTH),
    .EDGE_MODE (EDGE_MODE)
  ) u_edge_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (in_port),
    .sync_q  (sync_q),
    .edge_c  (edge_c)
  );

  assign wr_c = bus.chipselect & ~bus.write_n;

  // Register write decode; a new edge overrides a same-cycle clear
  always_comb begin
    out_next  = out_q;
    dir_next  = dir_q;
    mask_next = mask_q;
    cap_next  = cap_q | edge_c;
    if (wr_c) begin
      case (bus.address)
        ADDR_DATA:    out_next  = bus.writedata;
        ADDR_DIR:     dir_next  = bus.writedata;
        ADDR_IRQMASK: mask_next = bus.writedata;
        ADDR_EDGECAP: cap_next  = (cap_q & ~bus.writedata) | edge_c;
`ifdef PIO_BITSET_EN
        ADDR_OUTSET:  out_next  = out_q | bus.writedata;
        ADDR_OUTCLR:  out_next  = out_q & ~bus.writedata;
`else
        ADDR_OUTSET, ADDR_OUTCLR: ;
`endif
        default: ;
      endcase
    end
  end

  // Register state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= RESET_OUT;
      dir_q  <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_next;
      dir_q  <= dir_next;
      mask_q <= mask_next;
      cap_q  <= cap_next;
      irq_q  <= |(cap_q & mask_q);
    end
  end

  // Zero-latency read mux; unmapped and set/clear addresses read as zero
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:    bus.readdata = sync_q;
      ADDR_DIR:     bus.readdata = dir_q;
      ADDR_IRQMASK: bus.readdata = mask_q;
      ADDR_EDGECAP: bus.readdata = cap_q;
      default:      bus.readdata = '0;
    endcase
  end

  assign out_port = out_q;
  assign out_en   = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_pio_bidir.sv
// Directed bench for avalon_pio_bidir. dut_a: rising-edge capture with
// RESET_OUT=0x5A; dut_b: any-edge capture. Inputs driven and outputs sampled
// on the falling clock edge.
module tb_avalon_pio_bidir;
  import pio_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_a, out_a, oe_a;
  logic [W-1:0] in_b, out_b, oe_b;
  logic         irq_a, irq_b;
  int           checks = 0;
  int           passes = 0;
  logic [W-1:0] exp_set, exp_clr;

  avalon_pio_bidir_if #(.WIDTH(W)) bus_a ();
  avalon_pio_bidir_if #(.WIDTH(W)) bus_b ();

  avalon_pio_bidir #(.WIDTH(W), .RESET_OUT(8'h5A), .EDGE_MODE(EDGE_RISE)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_a),
    .out_port(out_a), .out_en(oe_a), .irq(irq_a));

  avalon_pio_bidir #(.WIDTH(W), .RESET_OUT(8'h00), .EDGE_MODE(EDGE_ANY)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .in_port(in_b),
    .out_port(out_b), .out_en(oe_b), .irq(irq_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One write cycle, entered and left at a falling edge
  task automatic wr(input int sel, input logic [2:0] a, input logic [W-1:0] d);
    if (sel == 0) begin
      bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    end else begin
      bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
    end
    @(negedge clk);
    if (sel == 0) begin
      bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
    end else begin
      bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
    end
  endtask

  task automatic rd(input int sel, input logic [2:0] a, input logic [W-1:0] exp, input string tag);
    logic [W-1:0] obs;
    if (sel == 0) bus_a.address = a; else bus_b.address = a;
    #1;
    obs = (sel == 0) ? bus_a.readdata : bus_b.readdata;
    check(tag, 32'(obs), 32'(exp));
  endtask

  initial begin
    reset_n = 1'b1;
    in_a = '0; in_b = '0;
    bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
    #2 reset_n = 1'b0;
    cycles(2);

    // Reset state
    check("rst_out_a", 32'(out_a), 32'h5A);
    check("rst_oe_a", 32'(oe_a), 32'h00);
    check("rst_irq_a", 32'(irq_a), 32'h0);
    check("rst_out_b", 32'(out_b), 32'h00);
    check("rst_oe_b", 32'(oe_b), 32'h00);
    rd(0, ADDR_EDGECAP, 8'h00, "rst_cap_a");
    rd(0, ADDR_IRQMASK, 8'h00, "rst_mask_a");
    reset_n = 1'b1;
    @(negedge clk);

    // DATA and DIR writes
    wr(0, ADDR_DATA, 8'hA5);
    check("out_a5", 32'(out_a), 32'hA5);
    rd(0, ADDR_DATA, 8'h00, "data_in_idle");
    wr(0, ADDR_DIR, 8'h0F);
    check("oe_0f", 32'(oe_a), 32'h0F);
    rd(0, ADDR_DIR, 8'h0F, "dir_rd");
    wr(0, ADDR_IRQMASK, 8'h08);
    rd(0, ADDR_IRQMASK, 8'h08, "mask_rd");

    // bit3 rising edge (bit3 is an output: capture regardless of DIR)
    @(negedge clk);
    in_a = 8'h08;
    @(negedge clk);
    rd(0, ADDR_EDGECAP, 8'h00, "cap_e1");
    @(negedge clk);
    rd(0, ADDR_EDGECAP, 8'h00, "cap_e2");
    rd(0, ADDR_DATA, 8'h08, "data_sync_e2");
    @(negedge clk);
    rd(0, ADDR_EDGECAP, 8'h08, "cap_e3");
    check("irq_e3", 32'(irq_a), 32'h0);
    @(negedge clk);
    check("irq_e4", 32'(irq_a), 32'h1);

    // Clear bit3; irq follows one cycle later
    wr(0, ADDR_EDGECAP, 8'h08);
    rd(0, ADDR_EDGECAP, 8'h00, "cap_w1c");
    check("irq_lag", 32'(irq_a), 32'h1);
    @(negedge clk);
    check("irq_clr", 32'(irq_a), 32'h0);

    // bit2 edge coinciding with a clear of bit2: edge wins
    in_a = 8'h0C;
    cycles(2);
    wr(0, ADDR_EDGECAP, 8'h04);
    rd(0, ADDR_EDGECAP, 8'h04, "edge_wins");
    wr(0, ADDR_EDGECAP, 8'h04);
    rd(0, ADDR_EDGECAP, 8'h00, "cap_b2_clr");

    // Falling edges ignored in rising mode
    in_a = 8'h00;
    cycles(4);
    rd(0, ADDR_EDGECAP, 8'h00, "fall_ignored");

    // Set/clear registers
`ifdef PIO_BITSET_EN
    exp_set = 8'h33; exp_clr = 8'h23;
`else
    exp_set = 8'h30; exp_clr = 8'h30;
`endif
    wr(0, ADDR_DATA, 8'h30);
    check("out_30", 32'(out_a), 32'h30);
    wr(0, ADDR_OUTSET, 8'h03);
    check("outset", 32'(out_a), 32'(exp_set));
    wr(0, ADDR_OUTCLR, 8'h10);
    check("outclr", 32'(out_a), 32'(exp_clr));
    rd(0, ADDR_OUTSET, 8'h00, "rd_addr4");
    rd(0, ADDR_OUTCLR, 8'h00, "rd_addr5");
    rd(0, 3'd7, 8'h00, "rd_addr7");

    // Any-edge mode on dut_b with mask 0
    @(negedge clk);
    in_b = 8'h01;
    cycles(3);
    rd(1, ADDR_EDGECAP, 8'h01, "any_rise");
    wr(1, ADDR_EDGECAP, 8'h01);
    rd(1, ADDR_EDGECAP, 8'h00, "any_clr");
    in_b = 8'h00;
    cycles(3);
    rd(1, ADDR_EDGECAP, 8'h01, "any_fall");
    @(negedge clk);
    check("any_irq_masked", 32'(irq_b), 32'h0);

    // Arm irq on dut_a, then reset during a write
    wr(0, ADDR_IRQMASK, 8'h08);
    in_a = 8'h08;
    cycles(4);
    check("irq_pre_rst", 32'(irq_a), 32'h1);
    bus_a.address = ADDR_DATA; bus_a.writedata = 8'hFF;
    bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    check("midwr_out", 32'(out_a), 32'h5A);
    check("midwr_irq", 32'(irq_a), 32'h0);
    check("midwr_oe", 32'(oe_a), 32'h00);
    rd(0, ADDR_EDGECAP, 8'h00, "midwr_cap");
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.address = ADDR_DATA;
    reset_n = 1'b1;

    // Pin high at release: exactly one rising edge
    cycles(2);
    rd(0, ADDR_EDGECAP, 8'h00, "rel_cap_e2");
    @(negedge clk);
    rd(0, ADDR_EDGECAP, 8'h08, "rel_cap_e3");
    wr(0, ADDR_EDGECAP, 8'h08);
    cycles(4);
    rd(0, ADDR_EDGECAP, 8'h00, "rel_one_edge");

    // First write after reset is honoured
    wr(0, ADDR_DATA, 8'h3C);
    check("post_rst_wr", 32'(out_a), 32'h3C);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/avalon_pio_bidir.md
AVALON_PIO_BIDIR -- requirements
Module: avalon_pio_bidir

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of PIO bits, legal range 1..32.
REQ-002 SHALL have parameter RESET_OUT, default 0: value of the output register after reset.
REQ-003 SHALL have parameter EDGE_MODE, default 0: 0 = rising, 1 = falling, 2 = any edge captured.
REQ-004 SHALL have port clk, input, 1: the single clock, rising-edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port address, input, 3: register select.
REQ-007 SHALL have port chipselect, input, 1: slave select.
REQ-008 SHALL have port write_n, input, 1: active-low write strobe.
REQ-009 SHALL have port writedata, input, WIDTH: write data.
REQ-010 SHALL have port readdata, output, WIDTH: read data, zero wait states.
REQ-011 SHALL have port in_port, input, WIDTH: asynchronous pin inputs.
REQ-012 SHALL have port out_port, output, WIDTH: output register value.
REQ-013 SHALL have port out_en, output, WIDTH: per-bit direction, 1 = drive. The pad tristate is external.
REQ-014 SHALL have port irq, output, 1: level interrupt.

Function
REQ-015 SHALL define a write as chipselect=1 and write_n=0 sampled at a clk edge. A write SHALL take effect on the next clk edge.
REQ-016 SHALL decode the register map as follows: 0 DATA (read: synchronised inputs; write: output register), 1 DIR, 2 IRQMASK, 3 EDGECAP (read: capture; write: 1 clears that bit), 4 OUTSET, 5 OUTCLR. Reads of 4 to 7 SHALL return 0.
REQ-017 SHALL make readdata purely combinational from address and current register state, with read latency 0.
REQ-018 SHALL pass in_port through a two-flop synchroniser per bit. A third flop SHALL hold the previous synchronised value for edge detection.
REQ-019 SHALL set an EDGECAP bit on the cycle its edge is detected, per EDGE_MODE. The bit SHALL stay set until cleared by software.
REQ-020 SHALL, when an edge is detected and a write-1-to-clear hits the same bit in the same cycle, leave the bit set (edge wins).
REQ-021 SHALL detect edges regardless of DIR. A bit configured as output still captures edges on its pin.
REQ-022 SHALL register irq as the OR over bits of (EDGECAP AND IRQMASK), one cycle after the state changes.
REQ-023 SHALL give in_port-to-EDGECAP latency of 3 clk edges. EDGECAP-to-irq latency SHALL be 1 clk edge.
REQ-024 SHALL drive out_port directly from the output register and out_en directly from DIR, with no added latency.

Reset
REQ-025 SHALL, on reset_n low, asynchronously set the output register to RESET_OUT.
REQ-026 SHALL, on reset_n low, asynchronously clear DIR, IRQMASK, EDGECAP, the synchroniser flops and irq to 0.
REQ-027 SHALL discard an access in progress when reset asserts mid-write. The first write after deassertion SHALL be honoured normally.
REQ-028 SHALL NOT report a spurious edge after reset, because the synchroniser and history flops all reset to 0. A pin that is high at release SHALL produce exactly one rising edge when EDGE_MODE is 0 or 2.

Configuration
REQ-029 SHALL implement OUTSET and OUTCLR only when macro PIO_BITSET_EN is defined.
- OUTSET write: out |= writedata.
- OUTCLR write: out &= ~writedata.
- Writes to DATA, OUTSET and OUTCLR are mutually exclusive by address.
REQ-030 SHALL, without PIO_BITSET_EN, ignore writes to addresses 4 and 5. Reads there SHALL return 0. No set/clear logic SHALL be synthesised.

Structure
REQ-031 SHALL place the register address constants and edge-mode encodings in shared package pio_pkg.
REQ-032 SHALL implement the per-bit synchroniser and edge detector as sub-module pio_edge_sync, parametrised by EDGE_MODE, instantiated once per bit or vectorised over WIDTH.

Verification
REQ-033 SHALL cover: WIDTH=8 write 0xA5 to DATA -> out_port=0xA5 the next cycle; write 0x0F to DIR -> out_en=0x0F.
REQ-034 SHALL cover: EDGE_MODE=0, in_port bit3 rises -> EDGECAP=0x08 on the 3rd edge; with IRQMASK=0x08, irq=1 one cycle later; write 0x08 to EDGECAP -> irq=0.
REQ-035 SHALL cover: a bit2 edge coinciding with a write of 0x04 to EDGECAP -> EDGECAP bit2 stays 1.
REQ-036 SHALL cover: with PIO_BITSET_EN and out=0x30, OUTSET 0x03 -> 0x33, then OUTCLR 0x10 -> 0x23; without the macro both writes leave 0x30 and reads return 0.
REQ-037 SHALL cover: RESET_OUT=0x5A, reset_n pulsed low mid-write of 0xFF -> out_port=0x5A, irq=0, EDGECAP=0.
REQ-038 SHALL cover: EDGE_MODE=2, toggle bit0 high then low with IRQMASK=0 -> EDGECAP bit0=1 and irq stays 0.
